tx_ordered_set_gen: RTL

TX_ORDERED_SET_GEN -- requirements
Module: tx_ordered_set_gen

---
 rtl/sgmii_pcs_pkg.sv | 32 +++
 rtl/tx_ordered_set_gen.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sgmii_pcs_pkg.sv
// Shared SGMII PCS definitions: 8b10b code-group byte values and the TX ordered-set FSM states.
// The CFG states exist only when SGMII_CFG_EN is defined.
package sgmii_pcs_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;   // /S/
    localparam logic [7:0] K29_7 = 8'hFD;   // /T/
    localparam logic [7:0] K23_7 = 8'hF7;   // /R/
    localparam logic [7:0] K30_7 = 8'hFE;   // /V/
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D2_2  = 8'h42;

    // State names the byte to be produced in the next output slot.
    typedef enum logic [3:0] {
        IDLE_K,
        IDLE_D,
        DATA,
        EOP_T,
        EOP_R,
        EOP_R2
`ifdef SGMII_CFG_EN
        ,
        CFG_K,
        CFG_D,
        CFG_LO,
        CFG_HI
`endif
    } tx_state_e;

endpackage

// File: rtl/tx_ordered_set_gen.sv
// GMII to 8b10b code-group ordered-set generator (idle, /S/ data /T/ /R/, optional /C/ sets).
// Optional SGMII configuration ordered sets are built when macro SGMII_CFG_EN is defined.
module tx_ordered_set_gen
    import sgmii_pcs_pkg::*;
#(
    parameter bit pDISP_IDLE = 1'b1
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [7:0]  i8_TxD,
    input  logic        i_TxEn,
    input  logic        i_TxEr,
    input  logic        i_Rd,
`ifdef SGMII_CFG_EN
    input  logic        i_XmitCfg,
    input  logic [15:0] i16_CfgReg,
`endif
    output logic [7:0]  o8_Dout,
    output logic        o_Kin,
    output logic        o_Even
);

    tx_state_e   state;
    tx_state_e   state_nxt;
    logic [7:0]  dout_nxt;
    logic        kin_nxt;

`ifdef SGMII_CFG_EN
    logic [15:0] cfg_word;
    logic [15:0] cfg_word_nxt;
    logic        cfg_c2;
    logic        cfg_c2_nxt;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state   <= IDLE_D;
            o8_Dout <= K28_5;
            o_Kin   <= 1'b1;
            o_Even  <= 1'b1;
`ifdef SGMII_CFG_EN
            cfg_word <= '0;
            cfg_c2   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            o8_Dout <= dout_nxt;
            o_Kin   <= kin_nxt;
            o_Even  <= ~o_Even;
`ifdef SGMII_CFG_EN
            cfg_word <= cfg_word_nxt;
            cfg_c2   <= cfg_c2_nxt;
`endif
        end
    end

    // The slot being decided has parity ~o_Even; IDLE_K is only ever entered ahead of an even slot.
    always_comb begin
        state_nxt = state;
        dout_nxt  = K28_5;
        kin_nxt   = 1'b1;
`ifdef SGMII_CFG_EN
        cfg_word_nxt = cfg_word;
        cfg_c2_nxt   = cfg_c2;
`endif
        case (state)
            IDLE_K: begin
`ifdef SGMII_CFG_EN
                if (i_XmitCfg) begin
                    dout_nxt     = K28_5;
                    kin_nxt      = 1'b1;
                    cfg_word_nxt = i16_CfgReg;
                    cfg_c2_nxt   = 1'b0;
                    state_nxt    = CFG_D;
                end else
`endif
                if (i_TxEn) begin
                    dout_nxt  = K27_7;
                    kin_nxt   = 1'b1;
                    state_nxt = DATA;
                end else begin
                    dout_nxt  = K28_5;
                    kin_nxt   = 1'b1;
                    state_nxt = IDLE_D;
                end
            end
            // Frame start here is deferred to IDLE_K, dropping this preamble byte.
            IDLE_D: begin
                dout_nxt  = (pDISP_IDLE && !i_Rd) ? D5_6 : D16_2;
                kin_nxt   = 1'b0;
                state_nxt = IDLE_K;
            end
            DATA: begin
                if (i_TxEn) begin
                    dout_nxt = i_TxEr ? K30_7 : i8_TxD;
                    kin_nxt  = i_TxEr;
                end else begin
                    dout_nxt  = K29_7;
                    kin_nxt   = 1'b1;
                    state_nxt = EOP_R;
                end
            end
            // /T/ is emitted straight from DATA, so EOP_T shares the first-/R/ behaviour.
            EOP_T, EOP_R: begin
                dout_nxt  = K23_7;
                kin_nxt   = 1'b1;
                state_nxt = o_Even ? IDLE_K : EOP_R2;
            end
            EOP_R2: begin
                dout_nxt  = K23_7;
                kin_nxt   = 1'b1;
                state_nxt = IDLE_K;
            end
`ifdef SGMII_CFG_EN
            CFG_K: begin
                dout_nxt     = K28_5;
                kin_nxt      = 1'b1;
                cfg_word_nxt = i16_CfgReg;
                state_nxt    = CFG_D;
            end
            CFG_D: begin
                dout_nxt  = cfg_c2 ? D2_2 : D21_5;
                kin_nxt   = 1'b0;
                state_nxt = CFG_LO;
            end
            CFG_LO: begin
                dout_nxt  = cfg_word[7:0];
                kin_nxt   = 1'b0;
                state_nxt = CFG_HI;
            end
            CFG_HI: begin
                dout_nxt   = cfg_word[15:8];
                kin_nxt    = 1'b0;
                cfg_c2_nxt = ~cfg_c2;
                state_nxt  = i_XmitCfg ? CFG_K : IDLE_K;
            end
`endif
            default: begin
                dout_nxt  = K28_5;
                kin_nxt   = 1'b1;
                state_nxt = IDLE_K;
            end
        endcase
    end

endmodule
